// File: rtl/sdram_wb_bridge.sv
// rtl/sdram_wb_bridge.sv - CPU SDRAM bus to SDRAM controller request/ack bridge
// Holds the controller in reset after bus reset, masks bytes, delays acks and times out stuck requests.
module sdram_wb_bridge #(
  parameter int DW      = 16,
  parameter int AW      = 21,
  parameter int RST_DLY = 4,
  parameter int ACK_DLY = 2,
  parameter int TMO     = 255
) (
  input  logic            clk_p,
  input  logic            sdram_reset,
  input  logic            sdram_stb,
  input  logic            sdram_we,
  input  logic [DW/8-1:0] sdram_sel,
  input  logic [AW-1:0]   sdram_adr,
  input  logic [DW-1:0]   sdram_out,
  output logic [DW-1:0]   sdram_dat,
  output logic            sdram_ack,
  output logic            sdram_err,
  output logic            sdram_ready,
  output logic            ctl_rst_n,
  input  logic            ctl_init_done,
  output logic            ctl_wr_req,
  output logic            ctl_rd_req,
  input  logic            ctl_wr_ack,
  input  logic            ctl_rd_ack,
  output logic [DW/8-1:0] ctl_dqm,
  output logic [AW-1:0]   ctl_addr,
  output logic [DW-1:0]   ctl_wdata,
  input  logic [DW-1:0]   ctl_rdata
);

  localparam int RCW = $clog2(RST_DLY + 1);
  localparam int ACW = $clog2(ACK_DLY + 1);
  localparam int TCW = $clog2(TMO + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_DLY);
  localparam logic [ACW-1:0] ACK_M1   = ACW'(ACK_DLY - 1);
  localparam logic [TCW-1:0] TMO_M1   = TCW'(TMO - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TMO);

  typedef enum logic [2:0] {HOLD, IDLE, REQ, ACKD, DONE, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] rst_cnt;
  logic [ACW-1:0] ack_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic           we_q, ack_r, err_r;
  logic           ack_hit, tmo_hit, busy;
  logic           accept, capture, set_ack, set_err, clr_flags;

  assign ack_hit    = we_q ? ctl_wr_ack : ctl_rd_ack;
  // >= so a timeout coinciding with a strobe drop still ends the drain
  assign tmo_hit    = (tmo_cnt >= TMO_M1);
  assign busy       = (state_q == REQ) || (state_q == DRAIN);
  assign ctl_wr_req = busy && we_q;
  assign ctl_rd_req = busy && !we_q;
  assign ctl_rst_n  = (state_q != HOLD);
  assign sdram_ack  = ack_r & sdram_stb;
  assign sdram_err  = err_r & sdram_stb;

  always_ff @(posedge clk_p) begin
    if (sdram_reset) state_q <= HOLD;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    set_ack   = 1'b0;
    set_err   = 1'b0;
    clr_flags = 1'b0;
    case (state_q)
      HOLD:  if (rst_cnt == RST_LAST) state_d = IDLE;
      IDLE:  if (sdram_stb && sdram_ready) begin
               accept  = 1'b1;
               state_d = REQ;
             end
      REQ:   if (ack_hit) begin
               // ack and abort on the same edge: treat like a finished drain
               if (sdram_stb) begin
                 capture = !we_q;
                 state_d = ACKD;
               end else begin
                 state_d = IDLE;
               end
             end else if (!sdram_stb) begin
               state_d = DRAIN;
             end else if (tmo_hit) begin
               set_err = 1'b1;
               state_d = DONE;
             end
      ACKD:  if (!sdram_stb) begin
               state_d = IDLE;
             end else if (ack_cnt == ACK_M1) begin
               set_ack = 1'b1;
               state_d = DONE;
             end
      DONE:  if (!sdram_stb) begin
               clr_flags = 1'b1;
               state_d   = IDLE;
             end
      DRAIN: if (ack_hit || tmo_hit) state_d = IDLE;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      rst_cnt     <= '0;
      ack_cnt     <= '0;
      tmo_cnt     <= '0;
      we_q        <= 1'b0;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      sdram_ready <= 1'b0;
      sdram_dat   <= '0;
      ctl_dqm     <= '0;
      ctl_addr    <= '0;
      ctl_wdata   <= '0;
    end else begin
      sdram_ready <= ctl_rst_n & ctl_init_done;
      if (state_q == HOLD && rst_cnt != RST_LAST) rst_cnt <= rst_cnt + 1'b1;
      ack_cnt <= (state_q == ACKD) ? ack_cnt + 1'b1 : '0;
      if (accept) begin
        we_q      <= sdram_we;
        ctl_addr  <= sdram_adr;
        ctl_wdata <= sdram_out;
        ctl_dqm   <= sdram_we ? ~sdram_sel : '0;
        tmo_cnt   <= '0;
      end else if (busy && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (capture) sdram_dat <= ctl_rdata;
      if (set_ack) ack_r <= 1'b1;
      if (set_err) err_r <= 1'b1;
      if (clr_flags) begin
        ack_r <= 1'b0;
        err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb/tb_sdram_wb_bridge.sv - directed self-checking bench for sdram_wb_bridge
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sdram_wb_bridge;
  localparam int DW = 16;
  localparam int AW = 21;
  localparam int SW = DW / 8;

  logic          clk_p = 1'b0;
  logic          sdram_reset, sdram_stb, sdram_we;
  logic [SW-1:0] sdram_sel;
  logic [AW-1:0] sdram_adr;
  logic [DW-1:0] sdram_out, sdram_dat, ctl_rdata, ctl_wdata;
  logic          sdram_ack, sdram_err, sdram_ready, ctl_rst_n, ctl_init_done;
  logic          ctl_wr_req, ctl_rd_req, ctl_wr_ack, ctl_rd_ack;
  logic [SW-1:0] ctl_dqm;
  logic [AW-1:0] ctl_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_p = ~clk_p;

  sdram_wb_bridge #(.DW(DW), .AW(AW), .RST_DLY(4), .ACK_DLY(2), .TMO(16)) dut (
    .clk_p(clk_p), .sdram_reset(sdram_reset), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
    .sdram_ack(sdram_ack), .sdram_err(sdram_err), .sdram_ready(sdram_ready),
    .ctl_rst_n(ctl_rst_n), .ctl_init_done(ctl_init_done), .ctl_wr_req(ctl_wr_req),
    .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack),
    .ctl_dqm(ctl_dqm), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_p);
  endtask

  initial begin
    sdram_reset = 1'b1; sdram_stb = 1'b0; sdram_we = 1'b0; sdram_sel = '0;
    sdram_adr = '0; sdram_out = '0; ctl_init_done = 1'b1;
    ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0; ctl_rdata = '0;
    step(3);
    chk("rst_ctl_rst_n", ctl_rst_n, 0);
    chk("rst_wr_req", ctl_wr_req, 0);
    chk("rst_rd_req", ctl_rd_req, 0);
    chk("rst_dqm", ctl_dqm, 0);
    chk("rst_addr", ctl_addr, 0);
    chk("rst_wdata", ctl_wdata, 0);
    chk("rst_dat", sdram_dat, 0);
    chk("rst_ack", sdram_ack, 0);
    chk("rst_err", sdram_err, 0);
    chk("rst_ready", sdram_ready, 0);

    // release: ctl_rst_n rises 4 edges after the first edge sampling reset low
    sdram_reset = 1'b0;
    step(4);
    chk("hold_rst_n_e4", ctl_rst_n, 0);
    step();
    chk("hold_rst_n_e5", ctl_rst_n, 1);
    chk("ready_lags", sdram_ready, 0);
    step();
    chk("ready_up", sdram_ready, 1);

    ctl_init_done = 1'b0;
    step();
    chk("ready_follows_init", sdram_ready, 0);
    sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b11; sdram_adr = 21'h1234; sdram_out = 16'hBEEF;
    step();
    chk("not_ready_blocks", ctl_wr_req, 0);
    sdram_stb = 1'b0; ctl_init_done = 1'b1;
    step();
    chk("ready_back", sdram_ready, 1);

    // full word write
    sdram_stb = 1'b1;
    step();
    chk("w1_wr_req", ctl_wr_req, 1);
    chk("w1_rd_req", ctl_rd_req, 0);
    chk("w1_addr", ctl_addr, 32'h1234);
    chk("w1_wdata", ctl_wdata, 32'hBEEF);
    chk("w1_dqm", ctl_dqm, 2'b00);
    step(2);
    chk("w1_req_held", ctl_wr_req, 1);
    ctl_wr_ack = 1'b1;
    step();
    ctl_wr_ack = 1'b0;
    chk("w1_req_drop", ctl_wr_req, 0);
    chk("w1_ack_ea", sdram_ack, 0);
    step();
    chk("w1_ack_ea1", sdram_ack, 0);
    step();
    chk("w1_ack_ea2", sdram_ack, 1);
    chk("w1_err", sdram_err, 0);
    sdram_stb = 1'b0;
    #1 chk("w1_ack_gated", sdram_ack, 0);
    step();

    // high byte write
    sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b10; sdram_adr = 21'h0010; sdram_out = 16'hAB00;
    step();
    chk("w2_dqm", ctl_dqm, 2'b01);
    chk("w2_wr_req", ctl_wr_req, 1);
    ctl_wr_ack = 1'b1;
    step();
    ctl_wr_ack = 1'b0;
    step(2);
    chk("w2_ack", sdram_ack, 1);
    sdram_stb = 1'b0;
    step();

    // read with a partial select is still full word
    sdram_stb = 1'b1; sdram_we = 1'b0; sdram_sel = 2'b01; sdram_adr = 21'h0042;
    step();
    chk("r1_rd_req", ctl_rd_req, 1);
    chk("r1_wr_req", ctl_wr_req, 0);
    chk("r1_dqm", ctl_dqm, 2'b00);
    chk("r1_addr", ctl_addr, 32'h42);
    ctl_rdata = 16'h5A5A; ctl_rd_ack = 1'b1;
    step();
    ctl_rd_ack = 1'b0; ctl_rdata = 16'h0000;
    chk("r1_dat", sdram_dat, 32'h5A5A);
    chk("r1_req_drop", ctl_rd_req, 0);
    step();
    chk("r1_ack_ea1", sdram_ack, 0);
    step();
    chk("r1_ack_ea2", sdram_ack, 1);
    sdram_stb = 1'b0;
    step();

    // abort 3 cycles into REQ; controller acks 5 cycles later
    sdram_stb = 1'b1; sdram_we = 1'b0; sdram_sel = 2'b11; sdram_adr = 21'h0077;
    step();
    chk("ab_rd_req", ctl_rd_req, 1);
    step(2);
    sdram_stb = 1'b0;
    step();
    chk("ab_drain_req", ctl_rd_req, 1);
    step(4);
    chk("ab_drain_req_late", ctl_rd_req, 1);
    ctl_rdata = 16'h1111; ctl_rd_ack = 1'b1;
    step();
    ctl_rd_ack = 1'b0; ctl_rdata = 16'h0000;
    chk("ab_req_drop", ctl_rd_req, 0);
    chk("ab_dat_kept", sdram_dat, 32'h5A5A);
    chk("ab_no_ack", sdram_ack, 0);

    // next access after the drain is served normally
    sdram_stb = 1'b1; sdram_we = 1'b1; sdram_sel = 2'b11; sdram_adr = 21'h0100; sdram_out = 16'h1357;
    step();
    chk("w3_wr_req", ctl_wr_req, 1);
    chk("w3_wdata", ctl_wdata, 32'h1357);
    ctl_wr_ack = 1'b1;
    step();
    ctl_wr_ack = 1'b0;
    step(2);
    chk("w3_ack", sdram_ack, 1);
    sdram_stb = 1'b0;
    step();

    ctl_wr_ack = 1'b1;
    step();
    ctl_wr_ack = 1'b0;
    chk("stray_ack_ignored", ctl_wr_req, 0);

    // timeout with TMO=16
    sdram_stb = 1'b1; sdram_we = 1'b1; sdram_adr = 21'h0200; sdram_out = 16'h0F0F;
    step();
    step(15);
    chk("to_req_e15", ctl_wr_req, 1);
    chk("to_err_e15", sdram_err, 0);
    step();
    chk("to_req_e16", ctl_wr_req, 0);
    chk("to_err_e16", sdram_err, 1);
    chk("to_no_ack", sdram_ack, 0);
    sdram_stb = 1'b0;
    #1 chk("to_err_gated", sdram_err, 0);
    step();

    // reset in the middle of a request
    sdram_stb = 1'b1; sdram_adr = 21'h0300;
    step();
    chk("mr_wr_req", ctl_wr_req, 1);
    sdram_reset = 1'b1;
    step();
    chk("mr_req_drop", ctl_wr_req, 0);
    chk("mr_rst_n", ctl_rst_n, 0);
    chk("mr_ready", sdram_ready, 0);
    sdram_stb = 1'b0;
    step();
    sdram_reset = 1'b0;
    step(4);
    chk("mr_hold_e4", ctl_rst_n, 0);
    step();
    chk("mr_hold_e5", ctl_rst_n, 1);
    step();
    chk("mr_ready_up", sdram_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
